// File: rtl/reg_dump_reader.sv
// -----------------------------------------------------------------------------
// reg_dump_reader
//
// Walks a contiguous, wrapping range of register-file addresses and streams
// each register out over a valid/ready interface as an (address, data) pair.
// Each word takes two cycles. In FETCH the register file is read and the
// result is snapshotted. In SEND the snapshot is held until the sink accepts
// it. After the last word is accepted, Done pulses for one cycle.
//
// Ports
//   Clk        : clock, all state updates on the rising edge
//   Reset      : asynchronous, active-high reset
//   Start      : begin a dump (only looked at while idle)
//   Abort      : cancel a dump in progress, returning to idle
//   FirstAddr  : first register to dump, captured with Start
//   LastAddr   : last register to dump (inclusive), captured with Start
//   RaddrA     : register-file read address (zero except while fetching)
//   RdData     : combinational register-file read data for RaddrA
//   OutData    : dumped word (registered snapshot)
//   OutAddr    : register index of OutData
//   OutValid   : OutData/OutAddr valid
//   OutReady   : sink accepts the current word
//   Busy       : a dump is in progress
//   Done       : one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module reg_dump_reader #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Abort,
  input  logic [D-1:0] FirstAddr,
  input  logic [D-1:0] LastAddr,
  output logic [D-1:0] RaddrA,
  input  logic [W-1:0] RdData,
  output logic [W-1:0] OutData,
  output logic [D-1:0] OutAddr,
  output logic         OutValid,
  input  logic         OutReady,
  output logic         Busy,
  output logic         Done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [D-1:0] cur_addr;
  logic [D-1:0] last_addr;
  logic         at_last;
  logic         start_ok;

  // The range is inclusive and may wrap, so the end of the dump is found by
  // equality with the captured last address rather than by a word count.
  assign at_last  = (cur_addr == last_addr);
  assign start_ok = Start && !Abort;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples the values that existed before the clock edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Abort overrides everything once a dump is under way,
  // including a handshake in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so every path drives state_next and no
    // latch is inferred.
    state_next = state;
    if (Abort && (state != IDLE)) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_ok) state_next = FETCH;
        FETCH:   state_next = SEND;
        SEND:    if (OutReady) state_next = at_last ? FIN : FETCH;
        FIN:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Address counter and output snapshot
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cur_addr  <= '0;
      last_addr <= '0;
      OutData   <= '0;
      OutAddr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            cur_addr  <= FirstAddr;
            last_addr <= LastAddr;
          end
        end
        FETCH: begin
          // The snapshot is taken here and held through SEND, so writes to the
          // register file while the sink stalls do not disturb OutData.
          if (!Abort) begin
            OutData <= RdData;
            OutAddr <= cur_addr;
          end
        end
        SEND: begin
          // The increment wraps naturally modulo 2**D.
          if (!Abort && OutReady && !at_last) begin
            cur_addr <= cur_addr + D'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    Busy     = (state != IDLE);
    OutValid = (state == SEND);
    Done     = (state == FIN);
    RaddrA   = (state == FETCH) ? cur_addr : '0;
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_reg_dump_reader
//
// Self-checking bench for reg_dump_reader. The register file is an array in
// the bench. The expected dump for a range is computed directly from the range
// arithmetic and the register-file contents at the time of Start. Inputs are
// driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_reg_dump_reader;

  localparam int W = 8;
  localparam int D = 3;
  localparam int N = 1 << D;
  localparam int BUDGET = 400;

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic         Abort;
  logic [D-1:0] FirstAddr;
  logic [D-1:0] LastAddr;
  logic [D-1:0] RaddrA;
  logic [W-1:0] RdData;
  logic [W-1:0] OutData;
  logic [D-1:0] OutAddr;
  logic         OutValid;
  logic         OutReady;
  logic         Busy;
  logic         Done;

  logic [W-1:0] rf [N];

  int vectors;
  int miscompares;

  // Expected and observed dump for the most recent collect() call.
  logic [D-1:0] exp_addr [$];
  logic [W-1:0] exp_data [$];
  logic [D-1:0] got_addr [$];
  logic [W-1:0] got_data [$];
  int           got_cyc  [$];
  int           done_cnt;
  int           done_cyc;
  int           first_valid;
  int           stab_err;
  bit           timed_out;

  reg_dump_reader #(.W(W), .D(D)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Abort    (Abort),
    .FirstAddr(FirstAddr),
    .LastAddr (LastAddr),
    .RaddrA   (RaddrA),
    .RdData   (RdData),
    .OutData  (OutData),
    .OutAddr  (OutAddr),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Busy     (Busy),
    .Done     (Done)
  );

  assign RdData = rf[RaddrA];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload();
    for (int i = 0; i < N; i++) rf[i] = '0;
    rf[4] = 8'h40;
    rf[5] = 8'h36;
    rf[6] = 8'h3E;
    rf[7] = 8'h3F;
  endtask

  // Reference model: the words a dump of [first..last] must produce, taken
  // from the register file as it stands when the dump starts.
  task automatic build_exp(input int first, input int last);
    int n;
    exp_addr.delete();
    exp_data.delete();
    n = ((last - first) % N + N) % N + 1;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(D'((first + i) % N));
      exp_data.push_back(rf[(first + i) % N]);
    end
  endtask

  // Issue a Start and record every accepted word until Done has been seen
  // and a few more idle cycles have passed. Cycle 1 is the first falling edge
  // after the rising edge that samples Start. OutReady is held low for the
  // first 'hold' valid cycles, then raised with probability ready_pct%.
  // With 'poke' set, Start is re-pulsed mid-dump and R5 is overwritten while
  // its word is being offered.
  task automatic collect(input int first, input int last, input int ready_pct,
                         input int hold, input bit poke);
    int           cyc;
    int           valid_seen;
    int           after;
    bit           have_prev;
    logic [D-1:0] pa;
    logic [W-1:0] pd;
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    done_cnt    = 0;
    done_cyc    = -1;
    first_valid = -1;
    stab_err    = 0;
    timed_out   = 0;
    valid_seen  = 0;
    after       = 0;
    have_prev   = 0;
    pa          = '0;
    pd          = '0;
    FirstAddr   = D'(first);
    LastAddr    = D'(last);
    Start       = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    cyc   = 1;
    forever begin
      if (poke) begin
        Start = (cyc == 3 || cyc == 4);
        if (Start) begin
          FirstAddr = '0;
          LastAddr  = '0;
        end
      end
      if (OutValid === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        if (have_prev && (OutAddr !== pa || OutData !== pd)) stab_err++;
        if (poke && OutAddr === 3'd5) rf[5] = 8'hA5;
        OutReady = (valid_seen >= hold) && ($urandom_range(0, 99) < ready_pct);
        valid_seen++;
        if (OutReady) begin
          got_addr.push_back(OutAddr);
          got_data.push_back(OutData);
          got_cyc.push_back(cyc);
          have_prev = 0;
        end else begin
          have_prev = 1;
          pa = OutAddr;
          pd = OutData;
        end
      end else begin
        OutReady  = 1'($urandom_range(0, 1));
        have_prev = 0;
      end
      if (Done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0) after++;
      if (after > 4) break;
      if (cyc >= BUDGET) begin
        timed_out = 1;
        break;
      end
      @(negedge Clk);
      cyc++;
    end
    OutReady = 1'b0;
    Start    = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    Reset = 1'b1;
    #3;
    vectors++;
    if ({OutValid, Busy, Done, RaddrA, OutAddr, OutData} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b busy=%b done=%b raddr=%0d oaddr=%0d odata=%h, want all 0",
               OutValid, Busy, Done, RaddrA, OutAddr, OutData);
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    vectors++;
    if (Busy !== 1'b0 || OutValid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b valid=%b, want 0 0", Busy, OutValid);
    end
  endtask

  // Range 4..7 with the sink always ready: checks data, latency and rate.
  task automatic test_basic();
    preload();
    build_exp(4, 7);
    collect(4, 7, 100, 0, 0);
    vectors++;
    if (timed_out || got_addr.size() != exp_addr.size()) begin
      miscompares++;
      $display("FAIL basic_count: got %0d words (timeout=%0b), want %0d", got_addr.size(), timed_out, exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      vectors++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_cyc[i] != 2 + 2 * i) begin
        miscompares++;
        $display("FAIL basic_word%0d: got (%0d,%h)@%0d, want (%0d,%h)@%0d", i, got_addr[i], got_data[i],
                 got_cyc[i], exp_addr[i], exp_data[i], 2 + 2 * i);
      end
    end
    vectors++;
    if (first_valid != 2 || done_cnt != 1 || got_cyc.size() == 0 || done_cyc != got_cyc[got_cyc.size()-1] + 1) begin
      miscompares++;
      $display("FAIL basic_timing: first_valid=%0d done_cnt=%0d done_cyc=%0d, want 2, 1, last accept+1",
               first_valid, done_cnt, done_cyc);
    end
  endtask

  // Wrapping ranges: 6..1 (four words) and 5..4 (all eight words).
  task automatic test_wrap();
    int firsts [2];
    int lasts  [2];
    firsts[0] = 6; lasts[0] = 1;
    firsts[1] = 5; lasts[1] = 4;
    preload();
    for (int t = 0; t < 2; t++) begin
      build_exp(firsts[t], lasts[t]);
      collect(firsts[t], lasts[t], 100, 0, 0);
      vectors++;
      if (timed_out || got_addr.size() != exp_addr.size() || done_cnt != 1) begin
        miscompares++;
        $display("FAIL wrap%0d_count: got %0d words, %0d done, want %0d words, 1 done",
                 t, got_addr.size(), done_cnt, exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        vectors++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
          miscompares++;
          $display("FAIL wrap%0d_word%0d: got (%0d,%h), want (%0d,%h)", t, i, got_addr[i], got_data[i],
                   exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  // Single word 5..5 with the sink stalling for four valid cycles.
  task automatic test_hold();
    preload();
    build_exp(5, 5);
    collect(5, 5, 100, 4, 0);
    vectors++;
    if (timed_out || got_addr.size() != 1 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL hold_count: got %0d words, %0d done, want 1, 1", got_addr.size(), done_cnt);
    end else if (got_addr[0] !== exp_addr[0] || got_data[0] !== exp_data[0] || got_cyc[0] != 6) begin
      miscompares++;
      $display("FAIL hold_word: got (%0d,%h)@%0d, want (%0d,%h)@6", got_addr[0], got_data[0], got_cyc[0],
               exp_addr[0], exp_data[0]);
    end
    vectors++;
    if (stab_err != 0) begin
      miscompares++;
      $display("FAIL hold_stable: %0d changes while stalled, want 0", stab_err);
    end
  endtask

  // Abort while the 2nd word is offered, in the same cycle as a handshake.
  task automatic test_abort();
    int idle_err;
    preload();
    FirstAddr = 3'd4;
    LastAddr  = 3'd7;
    Start     = 1'b1;
    OutReady  = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    vectors++;
    if (OutValid !== 1'b1 || OutAddr !== 3'd5) begin
      miscompares++;
      $display("FAIL abort_pre: valid=%b addr=%0d, want 1 5", OutValid, OutAddr);
    end
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    vectors++;
    if (OutValid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_post: valid=%b busy=%b done=%b, want 0 0 0", OutValid, Busy, Done);
    end
    idle_err = 0;
    repeat (5) begin
      @(negedge Clk);
      if (OutValid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) idle_err++;
    end
    // Abort also wins over Start in idle.
    Start = 1'b1;
    Abort = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    Abort = 1'b0;
    @(negedge Clk);
    if (Busy !== 1'b0) idle_err++;
    OutReady = 1'b0;
    vectors++;
    if (idle_err != 0) begin
      miscompares++;
      $display("FAIL abort_idle: %0d cycles with activity, want 0", idle_err);
    end
    build_exp(4, 7);
    collect(4, 7, 100, 0, 0);
    vectors++;
    if (timed_out || got_addr.size() != 4 || done_cnt != 1 || got_addr[0] !== exp_addr[0] || got_data[0] !== exp_data[0]) begin
      miscompares++;
      $display("FAIL abort_restart: %0d words, %0d done, first addr %0d, want 4, 1, %0d",
               got_addr.size(), done_cnt, (got_addr.size() > 0) ? got_addr[0] : 3'd0, exp_addr[0]);
    end
  endtask

  // Reset asserted between clock edges while fetching the 2nd word.
  task automatic test_reset_mid();
    int idle_err;
    preload();
    FirstAddr = 3'd4;
    LastAddr  = 3'd7;
    Start     = 1'b1;
    OutReady  = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    vectors++;
    if (RaddrA !== 3'd5 || OutData !== 8'h40) begin
      miscompares++;
      $display("FAIL rstmid_pre: raddr=%0d odata=%h, want 5 40", RaddrA, OutData);
    end
    #2 Reset = 1'b1;
    #1;
    vectors++;
    if ({OutValid, Busy, Done, RaddrA, OutAddr, OutData} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async: valid=%b busy=%b done=%b raddr=%0d oaddr=%0d odata=%h, want all 0",
               OutValid, Busy, Done, RaddrA, OutAddr, OutData);
    end
    @(negedge Clk);
    Reset = 1'b0;
    idle_err = 0;
    repeat (6) begin
      @(negedge Clk);
      if (OutValid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) idle_err++;
    end
    OutReady = 1'b0;
    vectors++;
    if (idle_err != 0) begin
      miscompares++;
      $display("FAIL rstmid_idle: %0d cycles with activity, want 0", idle_err);
    end
    build_exp(4, 7);
    collect(4, 7, 100, 0, 0);
    vectors++;
    if (timed_out || got_addr.size() != 4 || done_cnt != 1 || got_addr[0] !== exp_addr[0] || got_data[3] !== exp_data[3]) begin
      miscompares++;
      $display("FAIL rstmid_restart: %0d words, %0d done, want 4 words from addr %0d, 1 done",
               got_addr.size(), done_cnt, exp_addr[0]);
    end
  endtask

  // Start re-pulsed while busy, and R5 overwritten while its word is offered.
  task automatic test_busy_start();
    preload();
    build_exp(4, 7);
    collect(4, 7, 50, 0, 1);
    vectors++;
    if (timed_out || got_addr.size() != exp_addr.size() || done_cnt != 1) begin
      miscompares++;
      $display("FAIL busy_count: got %0d words, %0d done, want %0d, 1", got_addr.size(), done_cnt, exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      vectors++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL busy_word%0d: got (%0d,%h), want (%0d,%h)", i, got_addr[i], got_data[i],
                 exp_addr[i], exp_data[i]);
      end
    end
    vectors++;
    if (stab_err != 0) begin
      miscompares++;
      $display("FAIL busy_stable: %0d changes while stalled, want 0", stab_err);
    end
  endtask

  // Random register contents, ranges and sink back-pressure.
  task automatic test_random();
    int first;
    int last;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) rf[i] = W'($urandom);
      first = $urandom_range(0, N - 1);
      last  = $urandom_range(0, N - 1);
      build_exp(first, last);
      collect(first, last, $urandom_range(30, 100), $urandom_range(0, 2), 0);
      vectors++;
      if (timed_out || got_addr.size() != exp_addr.size() || done_cnt != 1 || stab_err != 0) begin
        miscompares++;
        $display("FAIL rand%0d_count: %0d..%0d got %0d words, %0d done, %0d unstable, want %0d, 1, 0",
                 t, first, last, got_addr.size(), done_cnt, stab_err, exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        vectors++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
          miscompares++;
          $display("FAIL rand%0d_word%0d: got (%0d,%h), want (%0d,%h)", t, i, got_addr[i], got_data[i],
                   exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Start       = 1'b0;
    Abort       = 1'b0;
    OutReady    = 1'b0;
    FirstAddr   = '0;
    LastAddr    = '0;
    preload();
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_abort();
    test_reset_mid();
    test_busy_start();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
